// File: rtl/maxpool2x2_stream_pkg.sv
// Shared definitions for the 2x2/stride-2 streaming max-pool stage.
package maxpool2x2_stream_pkg;

  // Datapath width of the upstream ReLU/zero-select mux.
  localparam int INTERNAL_BITS = 32;

  // Position of a pixel inside its 2x2 window, {row_odd, col_odd}.
  typedef enum logic [1:0] {
    PH_EVEN_EVEN = 2'b00,
    PH_EVEN_ODD  = 2'b01,
    PH_ODD_EVEN  = 2'b10,
    PH_ODD_ODD   = 2'b11
  } phase_t;

  // Address width for a memory of the given depth; never below one bit.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Window phase from the low bits of the row and column counters.
  function automatic phase_t pixel_phase(input logic row_odd, input logic col_odd);
    return phase_t'({row_odd, col_odd});
  endfunction

endpackage

// File: rtl/maxpool2x2_stream_line_buf.sv
// Half-width line buffer holding the per-window maxima of the previous even row.
import maxpool2x2_stream_pkg::*;

module pool_line_buf #(
  parameter int DATA_W = INTERNAL_BITS,
  parameter int DEPTH  = 14,
  parameter int ADDR_W = addr_bits(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Store the even-row pair maximum; contents are always written before read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The odd-row pixel combines with its column's entry in the same cycle.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max pooling over a row-major pixel stream.
// Even rows fold pixel pairs into the line buffer; odd rows fold the buffered
// value with their own pair and emit one registered result per window.
import maxpool2x2_stream_pkg::*;

module maxpool2x2_stream #(
  parameter int DATA_W = INTERNAL_BITS,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              frame_done
);

  localparam int COL_W   = addr_bits(IMG_W);
  localparam int ROW_W   = addr_bits(IMG_H);
  localparam int LB_DEPTH = IMG_W / 2;
  localparam int LB_AW   = addr_bits(LB_DEPTH);

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [DATA_W-1:0] hold;

  logic              accept;
  logic              col_last;
  logic              row_last;
  phase_t            phase;
  logic [LB_AW-1:0]  lb_addr;
  logic              lb_wr_en;
  logic [DATA_W-1:0] lb_rd_data;
  logic [DATA_W-1:0] pair_max;

  // Signed maximum; on a tie either operand is the same value.
  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // clear takes priority, so a pixel arriving with it is dropped.
  assign accept   = in_valid && !clear;
  assign col_last = (col == COL_W'(IMG_W - 1));
  assign row_last = (row == ROW_W'(IMG_H - 1));
  assign phase    = pixel_phase(row[0], col[0]);
  assign lb_addr  = LB_AW'(col >> 1);
  assign pair_max = smax(hold, in_data);
  assign lb_wr_en = accept && (phase == PH_EVEN_ODD);

  pool_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (LB_DEPTH),
    .ADDR_W (LB_AW)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (lb_wr_en),
    .wr_addr (lb_addr),
    .wr_data (pair_max),
    .rd_addr (lb_addr),
    .rd_data (lb_rd_data)
  );

  // Position counters, window accumulator and registered pooled output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      hold       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else if (clear) begin
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        case (phase)
          PH_EVEN_EVEN: hold <= in_data;
          PH_EVEN_ODD:  hold <= hold;
          PH_ODD_EVEN:  hold <= smax(lb_rd_data, in_data);
          PH_ODD_ODD: begin
            out_valid  <= 1'b1;
            out_data   <= pair_max;
            frame_done <= col_last && row_last;
          end
          default:      hold <= hold;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream on a 4x4 frame.
module tb_maxpool2x2_stream;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  maxpool2x2_stream #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs and return 1 time unit after the clock edge.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic c);
    in_valid = v;
    in_data  = d;
    clear    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got v=%0b d=%h fd=%0b exp 0/0/0", i, out_valid, out_data, frame_done);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b0);
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got v=%0b d=%h fd=%0b exp 0/0/0", i, out_valid, out_data, frame_done);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_frame_basic();
    logic [DW-1:0] exp_q [4] = '{32'd6, 32'd8, 32'd14, 32'd16};
    int k = 0;
    for (int i = 1; i <= 16; i++) begin
      int  idx = i - 1;
      logic ev = ((idx / 4) % 2 == 1) && (idx % 2 == 1);
      drive(1'b1, DW'(i), 1'b0);
      n_checks++;
      if (out_valid !== ev) begin
        n_fail++;
        $display("FAIL basic_valid pix=%0d got=%0b exp=%0b", i, out_valid, ev);
      end
      n_checks++;
      if (frame_done !== (i == 16)) begin
        n_fail++;
        $display("FAIL basic_frame_done pix=%0d got=%0b exp=%0b", i, frame_done, (i == 16));
      end
      if (ev) begin
        n_checks++;
        if (out_data !== exp_q[k]) begin
          n_fail++;
          $display("FAIL basic_data out=%0d got=%0d exp=%0d", k, out_data, exp_q[k]);
        end
        $display("basic out %0d data=%0d fd=%0b", k, out_data, frame_done);
        k++;
      end
    end
    drive(1'b0, '0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd16) begin
      n_fail++;
      $display("FAIL basic_hold got v=%0b d=%0d exp v=0 d=16", out_valid, out_data);
    end
  endtask

  task automatic test_signed();
    logic [DW-1:0] exp_q [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
    int k = 0;
    for (int idx = 0; idx < 16; idx++) begin
      logic ev = ((idx / 4) % 2 == 1) && (idx % 2 == 1);
      drive(1'b1, (idx == 4) ? 32'hFFFF_FFFF : 32'hFFFF_FFFB, 1'b0);
      n_checks++;
      if (out_valid !== ev) begin
        n_fail++;
        $display("FAIL signed_valid idx=%0d got=%0b exp=%0b", idx, out_valid, ev);
      end
      if (ev) begin
        n_checks++;
        if (out_data !== exp_q[k]) begin
          n_fail++;
          $display("FAIL signed_data out=%0d got=%h exp=%h", k, out_data, exp_q[k]);
        end
        $display("signed out %0d data=%h", k, out_data);
        k++;
      end
    end
  endtask

  task automatic test_bubbles();
    logic [DW-1:0] exp_q [4] = '{32'd6, 32'd8, 32'd14, 32'd16};
    logic [DW-1:0] last_d = 32'hFFFF_FFFB;
    int k = 0;
    for (int i = 1; i <= 16; i++) begin
      int  idx = i - 1;
      logic ev = ((idx / 4) % 2 == 1) && (idx % 2 == 1);
      int  gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        drive(1'b0, DW'($urandom), 1'b0);
        n_checks++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0 || out_data !== last_d) begin
          n_fail++;
          $display("FAIL bubble_gap pix=%0d got v=%0b fd=%0b d=%0d exp v=0 fd=0 d=%0d", i, out_valid, frame_done, out_data, last_d);
        end
      end
      drive(1'b1, DW'(i), 1'b0);
      n_checks++;
      if (out_valid !== ev || frame_done !== (i == 16)) begin
        n_fail++;
        $display("FAIL bubble_valid pix=%0d got v=%0b fd=%0b exp v=%0b fd=%0b", i, out_valid, frame_done, ev, (i == 16));
      end
      if (ev) begin
        n_checks++;
        if (out_data !== exp_q[k]) begin
          n_fail++;
          $display("FAIL bubble_data out=%0d got=%0d exp=%0d", k, out_data, exp_q[k]);
        end
        $display("bubble out %0d data=%0d", k, out_data);
        last_d = exp_q[k];
        k++;
      end
    end
  endtask

  task automatic test_clear();
    logic [DW-1:0] exp_q [4] = '{32'd106, 32'd108, 32'd114, 32'd116};
    int k = 0;
    for (int i = 1; i <= 6; i++) drive(1'b1, DW'(i), 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'd6) begin
      n_fail++;
      $display("FAIL clear_pre got v=%0b d=%0d exp v=1 d=6", out_valid, out_data);
    end
    drive(1'b1, 32'd999, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_pulse got v=%0b fd=%0b exp 0/0", out_valid, frame_done);
    end
    for (int i = 1; i <= 16; i++) begin
      int  idx = i - 1;
      logic ev = ((idx / 4) % 2 == 1) && (idx % 2 == 1);
      drive(1'b1, DW'(100 + i), 1'b0);
      n_checks++;
      if (out_valid !== ev || frame_done !== (i == 16)) begin
        n_fail++;
        $display("FAIL clear_valid pix=%0d got v=%0b fd=%0b exp v=%0b fd=%0b", i, out_valid, frame_done, ev, (i == 16));
      end
      if (ev) begin
        n_checks++;
        if (out_data !== exp_q[k]) begin
          n_fail++;
          $display("FAIL clear_data out=%0d got=%0d exp=%0d", k, out_data, exp_q[k]);
        end
        $display("clear out %0d data=%0d", k, out_data);
        k++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_q [8] = '{32'd6, 32'd8, 32'd14, 32'd16, 32'd22, 32'd24, 32'd30, 32'd32};
    logic [DW-1:0] exp_r [4] = '{32'd6, 32'd8, 32'd14, 32'd16};
    int k = 0;
    for (int i = 1; i <= 32; i++) begin
      int  idx = (i - 1) % 16;
      logic ev = ((idx / 4) % 2 == 1) && (idx % 2 == 1);
      logic efd = (i == 16) || (i == 32);
      drive(1'b1, DW'(i), 1'b0);
      n_checks++;
      if (out_valid !== ev || frame_done !== efd) begin
        n_fail++;
        $display("FAIL b2b_valid pix=%0d got v=%0b fd=%0b exp v=%0b fd=%0b", i, out_valid, frame_done, ev, efd);
      end
      if (ev) begin
        n_checks++;
        if (out_data !== exp_q[k]) begin
          n_fail++;
          $display("FAIL b2b_data out=%0d got=%0d exp=%0d", k, out_data, exp_q[k]);
        end
        $display("b2b out %0d data=%0d fd=%0b", k, out_data, frame_done);
        k++;
      end
    end
    // Third frame interrupted by an asynchronous reset during pixel 10.
    for (int i = 1; i <= 9; i++) drive(1'b1, DW'(200 + i), 1'b0);
    n_checks++;
    if (out_data !== 32'd208) begin
      n_fail++;
      $display("FAIL rst_pre got d=%0d exp d=208", out_data);
    end
    in_valid = 1'b1;
    in_data  = 32'd210;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async got v=%0b d=%0d fd=%0b exp 0/0/0", out_valid, out_data, frame_done);
    end
    drive(1'b0, '0, 1'b0);
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b0);
    k = 0;
    for (int i = 1; i <= 16; i++) begin
      int  idx = i - 1;
      logic ev = ((idx / 4) % 2 == 1) && (idx % 2 == 1);
      drive(1'b1, DW'(i), 1'b0);
      n_checks++;
      if (out_valid !== ev || frame_done !== (i == 16)) begin
        n_fail++;
        $display("FAIL rst_restart_valid pix=%0d got v=%0b fd=%0b exp v=%0b fd=%0b", i, out_valid, frame_done, ev, (i == 16));
      end
      if (ev) begin
        n_checks++;
        if (out_data !== exp_r[k]) begin
          n_fail++;
          $display("FAIL rst_restart_data out=%0d got=%0d exp=%0d", k, out_data, exp_r[k]);
        end
        $display("restart out %0d data=%0d", k, out_data);
        k++;
      end
    end
    drive(1'b0, '0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_frame_basic();
    test_signed();
    test_bubbles();
    test_clear();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
